// File: rtl/rv32_ctrl_pkg.sv
// Shared encodings for the RV32IM ID-stage control unit: opcodes, funct7
// values, ALU/MULDIV operation codes, FSM states and the control bundle.
package rv32_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [4:0] {
    ALU_NOP    = 5'd0,
    ALU_ADD    = 5'd1,
    ALU_SUB    = 5'd2,
    ALU_SLL    = 5'd3,
    ALU_SLT    = 5'd4,
    ALU_SLTU   = 5'd5,
    ALU_XOR    = 5'd6,
    ALU_SRL    = 5'd7,
    ALU_SRA    = 5'd8,
    ALU_OR     = 5'd9,
    ALU_AND    = 5'd10,
    ALU_LUI    = 5'd11,
    ALU_MUL    = 5'd12,
    ALU_MULH   = 5'd13,
    ALU_MULHSU = 5'd14,
    ALU_MULHU  = 5'd15,
    ALU_DIV    = 5'd16,
    ALU_DIVU   = 5'd17,
    ALU_REM    = 5'd18,
    ALU_REMU   = 5'd19
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_BUSY = 2'd1,
    DIV_BUSY = 2'd2
  } state_t;

  typedef struct packed {
    logic write_en;
    logic mem_write;
    logic mem_read;
    logic branch;
    logic jump;
    logic pc_select;
    logic imm_select;
    logic jalr_select;
    logic data_mem_select;
  } ctrl_t;

  function automatic alu_op_t base_alu(logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic alu_op_t muldiv_alu(logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_MUL;
      3'b001:  return ALU_MULH;
      3'b010:  return ALU_MULHSU;
      3'b011:  return ALU_MULHU;
      3'b100:  return ALU_DIV;
      3'b101:  return ALU_DIVU;
      3'b110:  return ALU_REM;
      default: return ALU_REMU;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Pure combinational RV32IM decode: control bundle, ALU op and M-class flags.
// Anything not explicitly recognised collapses to an all-zero illegal result.
module ctrl_decode
  import rv32_ctrl_pkg::*;
#(
  parameter int ENABLE_M = 1
) (
  input  logic [6:0] opcode_i,
  input  logic [2:0] func3_i,
  input  logic [6:0] func7_i,
  output logic [8:0] ctrl_o,
  output logic [4:0] alu_o,
  output logic       illegal_o,
  output logic       is_mul_o,
  output logic       is_div_o
);

  ctrl_t   ctrl;
  alu_op_t alu;
  logic    legal;
  logic    is_mul;
  logic    is_div;

  always_comb begin
    ctrl   = '0;
    alu    = ALU_NOP;
    legal  = 1'b0;
    is_mul = 1'b0;
    is_div = 1'b0;
    case (opcode_i)
      OP_R: begin
        if (func7_i == F7_BASE) begin
          legal = 1'b1;
          alu   = base_alu(func3_i);
        end else if (func7_i == F7_ALT) begin
          if (func3_i == 3'b000) begin
            legal = 1'b1;
            alu   = ALU_SUB;
          end else if (func3_i == 3'b101) begin
            legal = 1'b1;
            alu   = ALU_SRA;
          end
        end else if (func7_i == F7_MULDIV && ENABLE_M != 0) begin
          legal  = 1'b1;
          alu    = muldiv_alu(func3_i);
          is_mul = ~func3_i[2];
          is_div = func3_i[2];
        end
        ctrl.write_en = 1'b1;
      end
      OP_LOAD: begin
        legal = (func3_i != 3'b011) && (func3_i != 3'b110) && (func3_i != 3'b111);
        alu   = ALU_ADD;
        ctrl.write_en        = 1'b1;
        ctrl.mem_read        = 1'b1;
        ctrl.imm_select      = 1'b1;
        ctrl.data_mem_select = 1'b1;
      end
      OP_IMM: begin
        if (func3_i == 3'b001) begin
          legal = (func7_i == F7_BASE);
          alu   = ALU_SLL;
        end else if (func3_i == 3'b101) begin
          legal = (func7_i == F7_BASE) || (func7_i == F7_ALT);
          alu   = (func7_i == F7_ALT) ? ALU_SRA : ALU_SRL;
        end else begin
          legal = 1'b1;
          alu   = base_alu(func3_i);
        end
        ctrl.write_en   = 1'b1;
        ctrl.imm_select = 1'b1;
      end
      OP_STORE: begin
        legal = (func3_i == 3'b000) || (func3_i == 3'b001) || (func3_i == 3'b010);
        alu   = ALU_ADD;
        ctrl.mem_write  = 1'b1;
        ctrl.imm_select = 1'b1;
      end
      OP_BRANCH: begin
        legal = (func3_i != 3'b010) && (func3_i != 3'b011);
        alu   = ALU_SUB;
        ctrl.branch = 1'b1;
      end
      OP_JAL: begin
        legal = 1'b1;
        alu   = ALU_ADD;
        ctrl.write_en  = 1'b1;
        ctrl.jump      = 1'b1;
        ctrl.pc_select = 1'b1;
      end
      OP_JALR: begin
        legal = (func3_i == 3'b000);
        alu   = ALU_ADD;
        ctrl.write_en    = 1'b1;
        ctrl.jump        = 1'b1;
        ctrl.jalr_select = 1'b1;
        ctrl.imm_select  = 1'b1;
      end
      OP_LUI: begin
        legal = 1'b1;
        alu   = ALU_LUI;
        ctrl.write_en   = 1'b1;
        ctrl.imm_select = 1'b1;
      end
      OP_AUIPC: begin
        legal = 1'b1;
        alu   = ALU_ADD;
        ctrl.write_en   = 1'b1;
        ctrl.imm_select = 1'b1;
        ctrl.pc_select  = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    // Illegal encodings must never leak partial control bits into EX.
    if (!legal) begin
      ctrl   = '0;
      alu    = ALU_NOP;
      is_mul = 1'b0;
      is_div = 1'b0;
    end
  end

  assign ctrl_o    = ctrl;
  assign alu_o     = alu;
  assign illegal_o = ~legal;
  assign is_mul_o  = is_mul;
  assign is_div_o  = is_div;

endmodule

// File: rtl/control_unit_pipelined.sv
// ID-stage control unit: decode into the ID/EX register, with stall/flush and
// a busy FSM that holds EX and back-pressures fetch during multi-cycle MUL/DIV.
module control_unit_pipelined
  import rv32_ctrl_pkg::*;
#(
  parameter int ENABLE_M   = 1,
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 32
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       INSTR_VALID,
  input  logic [6:0] OPCODE,
  input  logic [2:0] FUNC3,
  input  logic [6:0] FUNC7,
  input  logic       STALL_IN,
  input  logic       FLUSH,
  output logic       DECODE_STALL,
  output logic       EX_VALID,
  output logic       WRITE_EN,
  output logic       MEM_WRITE,
  output logic       MEM_READ,
  output logic       BRANCH,
  output logic       JUMP,
  output logic       PC_SELECT,
  output logic       IMM_SELECT,
  output logic       JALR_SELECT,
  output logic       DATA_MEM_SELECT,
  output logic [4:0] ALU_OP,
  output logic       MULDIV_START,
  output logic       MULDIV_ABORT,
  output logic       ILLEGAL
);

  localparam logic [5:0] MUL_INIT = 6'(MUL_CYCLES - 1);
  localparam logic [5:0] DIV_INIT = 6'(DIV_CYCLES - 1);

  logic [8:0] dec_ctrl;
  logic [4:0] dec_alu;
  logic       dec_illegal;
  logic       dec_is_mul;
  logic       dec_is_div;

  state_t     state_q,   state_d;
  logic [5:0] cnt_q,     cnt_d;
  ctrl_t      ctrl_q,    ctrl_d;
  logic [4:0] alu_q,     alu_d;
  logic       valid_q,   valid_d;
  logic       illegal_q, illegal_d;
  logic       start_q,   start_d;
  logic       abort_q,   abort_d;

  ctrl_decode #(.ENABLE_M(ENABLE_M)) u_decode (
    .opcode_i  (OPCODE),
    .func3_i   (FUNC3),
    .func7_i   (FUNC7),
    .ctrl_o    (dec_ctrl),
    .alu_o     (dec_alu),
    .illegal_o (dec_illegal),
    .is_mul_o  (dec_is_mul),
    .is_div_o  (dec_is_div)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ctrl_q    <= '0;
      alu_q     <= '0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      start_q   <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ctrl_q    <= ctrl_d;
      alu_q     <= alu_d;
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
      start_q   <= start_d;
      abort_q   <= abort_d;
    end
  end

  // Counter holds the remaining busy cycles; the last one returns to IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (FLUSH) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (STALL_IN) begin
      state_d = state_q;
    end else if (state_q != IDLE) begin
      if (cnt_q <= 6'd1) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q - 6'd1;
      end
    end else if (INSTR_VALID && dec_is_mul && MUL_CYCLES > 1) begin
      state_d = MUL_BUSY;
      cnt_d   = MUL_INIT;
    end else if (INSTR_VALID && dec_is_div && DIV_CYCLES > 1) begin
      state_d = DIV_BUSY;
      cnt_d   = DIV_INIT;
    end
  end

  // Holding EX (stall or busy) keeps the bundle but never re-fires START.
  always_comb begin
    ctrl_d    = ctrl_q;
    alu_d     = alu_q;
    valid_d   = valid_q;
    illegal_d = illegal_q;
    start_d   = 1'b0;
    abort_d   = 1'b0;
    if (FLUSH) begin
      ctrl_d    = '0;
      alu_d     = '0;
      valid_d   = 1'b0;
      illegal_d = 1'b0;
      abort_d   = (state_q != IDLE);
    end else if (!STALL_IN && state_q == IDLE) begin
      if (INSTR_VALID) begin
        ctrl_d    = dec_ctrl;
        alu_d     = dec_alu;
        valid_d   = 1'b1;
        illegal_d = dec_illegal;
        start_d   = dec_is_mul | dec_is_div;
      end else begin
        ctrl_d    = '0;
        alu_d     = '0;
        valid_d   = 1'b0;
        illegal_d = 1'b0;
      end
    end
  end

  assign DECODE_STALL    = (state_q != IDLE);
  assign EX_VALID        = valid_q;
  assign WRITE_EN        = ctrl_q.write_en;
  assign MEM_WRITE       = ctrl_q.mem_write;
  assign MEM_READ        = ctrl_q.mem_read;
  assign BRANCH          = ctrl_q.branch;
  assign JUMP            = ctrl_q.jump;
  assign PC_SELECT       = ctrl_q.pc_select;
  assign IMM_SELECT      = ctrl_q.imm_select;
  assign JALR_SELECT     = ctrl_q.jalr_select;
  assign DATA_MEM_SELECT = ctrl_q.data_mem_select;
  assign ALU_OP          = alu_q;
  assign MULDIV_START    = start_q;
  assign MULDIV_ABORT    = abort_q;
  assign ILLEGAL         = illegal_q;

endmodule

// File: tb/tb_control_unit_pipelined.sv
// Scoreboarded bench for control_unit_pipelined: one instance with the M
// extension and default latencies, one with ENABLE_M = 0, fed identical stimulus.
module tb_control_unit_pipelined;

  localparam logic [4:0] A_NOP = 5'd0,  A_ADD = 5'd1,  A_SUB = 5'd2,  A_SLL = 5'd3;
  localparam logic [4:0] A_XOR = 5'd6,  A_SRA = 5'd8,  A_OR = 5'd9,   A_AND = 5'd10;
  localparam logic [4:0] A_LUI = 5'd11, A_MUL = 5'd12, A_MULH = 5'd13, A_MULHSU = 5'd14;
  localparam logic [4:0] A_DIV = 5'd16;

  // {we, mem_write, mem_read, branch, jump, pc_sel, imm_sel, jalr_sel, dmem_sel}
  localparam logic [8:0] C_R   = 9'b100000000;
  localparam logic [8:0] C_LD  = 9'b101000101;
  localparam logic [8:0] C_IMM = 9'b100000100;
  localparam logic [8:0] C_ST  = 9'b010000100;
  localparam logic [8:0] C_BR  = 9'b000100000;
  localparam logic [8:0] C_JAL = 9'b100011000;
  localparam logic [8:0] C_JR  = 9'b100010110;
  localparam logic [8:0] C_AUI = 9'b100001100;

  typedef logic [17:0] vec_t;
  typedef struct packed {
    logic       v;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       st;
    logic       fl;
    logic       rst;
  } stim_t;

  logic CLK, RESET, INSTR_VALID, STALL_IN, FLUSH;
  logic [6:0] OPCODE, FUNC7;
  logic [2:0] FUNC3;

  logic DECODE_STALL, EX_VALID, WRITE_EN, MEM_WRITE, MEM_READ, BRANCH, JUMP;
  logic PC_SELECT, IMM_SELECT, JALR_SELECT, DATA_MEM_SELECT, MULDIV_START, MULDIV_ABORT, ILLEGAL;
  logic [4:0] ALU_OP;

  logic n_DECODE_STALL, n_EX_VALID, n_WRITE_EN, n_MEM_WRITE, n_MEM_READ, n_BRANCH, n_JUMP;
  logic n_PC_SELECT, n_IMM_SELECT, n_JALR_SELECT, n_DATA_MEM_SELECT, n_MULDIV_START, n_MULDIV_ABORT, n_ILLEGAL;
  logic [4:0] n_ALU_OP;

  int   n_vec  = 0;
  int   n_fail = 0;
  vec_t exp_q[$];
  vec_t exp_nom_q[$];
  logic exp_stall_q[$];

  control_unit_pipelined dut (
    .CLK(CLK), .RESET(RESET), .INSTR_VALID(INSTR_VALID), .OPCODE(OPCODE), .FUNC3(FUNC3),
    .FUNC7(FUNC7), .STALL_IN(STALL_IN), .FLUSH(FLUSH), .DECODE_STALL(DECODE_STALL),
    .EX_VALID(EX_VALID), .WRITE_EN(WRITE_EN), .MEM_WRITE(MEM_WRITE), .MEM_READ(MEM_READ),
    .BRANCH(BRANCH), .JUMP(JUMP), .PC_SELECT(PC_SELECT), .IMM_SELECT(IMM_SELECT),
    .JALR_SELECT(JALR_SELECT), .DATA_MEM_SELECT(DATA_MEM_SELECT), .ALU_OP(ALU_OP),
    .MULDIV_START(MULDIV_START), .MULDIV_ABORT(MULDIV_ABORT), .ILLEGAL(ILLEGAL)
  );

  control_unit_pipelined #(.ENABLE_M(0)) dut_nom (
    .CLK(CLK), .RESET(RESET), .INSTR_VALID(INSTR_VALID), .OPCODE(OPCODE), .FUNC3(FUNC3),
    .FUNC7(FUNC7), .STALL_IN(STALL_IN), .FLUSH(FLUSH), .DECODE_STALL(n_DECODE_STALL),
    .EX_VALID(n_EX_VALID), .WRITE_EN(n_WRITE_EN), .MEM_WRITE(n_MEM_WRITE), .MEM_READ(n_MEM_READ),
    .BRANCH(n_BRANCH), .JUMP(n_JUMP), .PC_SELECT(n_PC_SELECT), .IMM_SELECT(n_IMM_SELECT),
    .JALR_SELECT(n_JALR_SELECT), .DATA_MEM_SELECT(n_DATA_MEM_SELECT), .ALU_OP(n_ALU_OP),
    .MULDIV_START(n_MULDIV_START), .MULDIV_ABORT(n_MULDIV_ABORT), .ILLEGAL(n_ILLEGAL)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic vec_t mk(logic v, logic il, logic [4:0] a, logic [8:0] c, logic s, logic ab);
    return {v, il, a, c, s, ab};
  endfunction

  function automatic stim_t ins(logic [6:0] op, logic [2:0] f3, logic [6:0] f7);
    return '{v: 1'b1, op: op, f3: f3, f7: f7, st: 1'b0, fl: 1'b0, rst: 1'b0};
  endfunction

  function automatic vec_t obs_main();
    return {EX_VALID, ILLEGAL, ALU_OP, WRITE_EN, MEM_WRITE, MEM_READ, BRANCH, JUMP,
            PC_SELECT, IMM_SELECT, JALR_SELECT, DATA_MEM_SELECT, MULDIV_START, MULDIV_ABORT};
  endfunction

  function automatic vec_t obs_nom();
    return {n_EX_VALID, n_ILLEGAL, n_ALU_OP, n_WRITE_EN, n_MEM_WRITE, n_MEM_READ, n_BRANCH, n_JUMP,
            n_PC_SELECT, n_IMM_SELECT, n_JALR_SELECT, n_DATA_MEM_SELECT, n_MULDIV_START, n_MULDIV_ABORT};
  endfunction

  // Drive one cycle of stimulus, queue what each DUT must show after the edge.
  task automatic drive(input stim_t s, input vec_t e, input logic es, input vec_t en);
    RESET       = s.rst;
    INSTR_VALID = s.v;
    OPCODE      = s.op;
    FUNC3       = s.f3;
    FUNC7       = s.f7;
    STALL_IN    = s.st;
    FLUSH       = s.fl;
    exp_q.push_back(e);
    exp_stall_q.push_back(es);
    exp_nom_q.push_back(en);
    @(posedge CLK);
    #1;
  endtask

  function automatic vec_t ill();
    return mk(1'b1, 1'b1, A_NOP, 9'b0, 1'b0, 1'b0);
  endfunction

  function automatic stim_t i_add(); return ins(7'b0110011, 3'b000, 7'b0000000); endfunction
  function automatic stim_t i_div(); return ins(7'b0110011, 3'b100, 7'b0000001); endfunction

  task automatic test_reset();
    stim_t s;
    vec_t  e, en;
    logic  es;
    s = i_add();
    s.rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(s, '0, 1'b0, '0);
      e = exp_q.pop_front(); en = exp_nom_q.pop_front(); es = exp_stall_q.pop_front();
      n_vec += 3;
      if (obs_main() !== e) begin n_fail++; $display("[TB] FAIL reset_outputs: got %h expected %h", obs_main(), e); end
      if (DECODE_STALL !== es) begin n_fail++; $display("[TB] FAIL reset_stall: got %b expected %b", DECODE_STALL, es); end
      if (obs_nom() !== en) begin n_fail++; $display("[TB] FAIL reset_nom: got %h expected %h", obs_nom(), en); end
    end
  endtask

  task automatic test_decode();
    stim_t s[$];
    vec_t  ev[$];
    vec_t  e, en;
    logic  es;
    s.push_back(i_add());                          ev.push_back(mk(1, 0, A_ADD, C_R, 0, 0));
    s.push_back(ins(7'b0100011, 3'b010, 7'h00));   ev.push_back(mk(1, 0, A_ADD, C_ST, 0, 0));
    s.push_back(ins(7'b0000011, 3'b010, 7'h00));   ev.push_back(mk(1, 0, A_ADD, C_LD, 0, 0));
    s.push_back(ins(7'b0000011, 3'b101, 7'h00));   ev.push_back(mk(1, 0, A_ADD, C_LD, 0, 0));
    s.push_back(ins(7'b0000011, 3'b011, 7'h00));   ev.push_back(ill());
    s.push_back(ins(7'b0100011, 3'b100, 7'h00));   ev.push_back(ill());
    s.push_back(ins(7'b0010011, 3'b000, 7'h55));   ev.push_back(mk(1, 0, A_ADD, C_IMM, 0, 0));
    s.push_back(ins(7'b0010011, 3'b110, 7'h2a));   ev.push_back(mk(1, 0, A_OR, C_IMM, 0, 0));
    s.push_back(ins(7'b0010011, 3'b001, 7'h00));   ev.push_back(mk(1, 0, A_SLL, C_IMM, 0, 0));
    s.push_back(ins(7'b0010011, 3'b001, 7'h20));   ev.push_back(ill());
    s.push_back(ins(7'b0010011, 3'b101, 7'h20));   ev.push_back(mk(1, 0, A_SRA, C_IMM, 0, 0));
    s.push_back(ins(7'b1100011, 3'b000, 7'h00));   ev.push_back(mk(1, 0, A_SUB, C_BR, 0, 0));
    s.push_back(ins(7'b1100011, 3'b110, 7'h00));   ev.push_back(mk(1, 0, A_SUB, C_BR, 0, 0));
    s.push_back(ins(7'b1100011, 3'b010, 7'h00));   ev.push_back(ill());
    s.push_back(ins(7'b1101111, 3'b011, 7'h11));   ev.push_back(mk(1, 0, A_ADD, C_JAL, 0, 0));
    s.push_back(ins(7'b1100111, 3'b000, 7'h00));   ev.push_back(mk(1, 0, A_ADD, C_JR, 0, 0));
    s.push_back(ins(7'b1100111, 3'b001, 7'h00));   ev.push_back(ill());
    s.push_back(ins(7'b0110111, 3'b101, 7'h7f));   ev.push_back(mk(1, 0, A_LUI, C_IMM, 0, 0));
    s.push_back(ins(7'b0010111, 3'b010, 7'h03));   ev.push_back(mk(1, 0, A_ADD, C_AUI, 0, 0));
    s.push_back(ins(7'b0110011, 3'b000, 7'h20));   ev.push_back(mk(1, 0, A_SUB, C_R, 0, 0));
    s.push_back(ins(7'b0110011, 3'b001, 7'h20));   ev.push_back(ill());
    s.push_back(ins(7'b0110011, 3'b100, 7'h00));   ev.push_back(mk(1, 0, A_XOR, C_R, 0, 0));
    s.push_back(ins(7'b0110011, 3'b111, 7'h00));   ev.push_back(mk(1, 0, A_AND, C_R, 0, 0));
    s.push_back(ins(7'b1111111, 3'b000, 7'h00));   ev.push_back(ill());
    s.push_back(i_add());                          ev.push_back(mk(0, 0, A_NOP, 9'b0, 0, 0));
    s[s.size()-1].v = 1'b0;
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i], ev[i], 1'b0, ev[i]);
      e = exp_q.pop_front(); en = exp_nom_q.pop_front(); es = exp_stall_q.pop_front();
      n_vec += 3;
      if (obs_main() !== e) begin n_fail++; $display("[TB] FAIL decode[%0d]: got %h expected %h", i, obs_main(), e); end
      if (DECODE_STALL !== es) begin n_fail++; $display("[TB] FAIL decode_stall[%0d]: got %b expected %b", i, DECODE_STALL, es); end
      if (obs_nom() !== en) begin n_fail++; $display("[TB] FAIL decode_nom[%0d]: got %h expected %h", i, obs_nom(), en); end
    end
  endtask

  task automatic test_stall_flush_idle();
    stim_t s;
    vec_t  eadd, esub, e, en;
    logic  es;
    eadd = mk(1, 0, A_ADD, C_R, 0, 0);
    esub = mk(1, 0, A_SUB, C_R, 0, 0);
    for (int n = 1; n <= 4; n++) begin
      s = (n == 1) ? i_add() : ins(7'b0110011, 3'b000, 7'h20);
      s.st = (n == 2 || n == 3);
      s.fl = (n == 3);
      e = (n <= 2) ? eadd : ((n == 3) ? vec_t'(0) : esub);
      drive(s, e, 1'b0, e);
      e = exp_q.pop_front(); en = exp_nom_q.pop_front(); es = exp_stall_q.pop_front();
      n_vec += 3;
      if (obs_main() !== e) begin n_fail++; $display("[TB] FAIL idle_stall_flush[%0d]: got %h expected %h", n, obs_main(), e); end
      if (DECODE_STALL !== es) begin n_fail++; $display("[TB] FAIL idle_stall_flush_stall[%0d]: got %b expected %b", n, DECODE_STALL, es); end
      if (obs_nom() !== en) begin n_fail++; $display("[TB] FAIL idle_stall_flush_nom[%0d]: got %h expected %h", n, obs_nom(), en); end
    end
  endtask

  task automatic test_div();
    stim_t s;
    vec_t  e, en;
    logic  es;
    int    stall_cycles = 0;
    for (int n = 1; n <= 33; n++) begin
      s  = (n == 1) ? i_div() : i_add();
      e  = (n == 1) ? mk(1, 0, A_DIV, C_R, 1, 0) :
           (n <= 32) ? mk(1, 0, A_DIV, C_R, 0, 0) : mk(1, 0, A_ADD, C_R, 0, 0);
      en = (n == 1) ? ill() : mk(1, 0, A_ADD, C_R, 0, 0);
      drive(s, e, (n <= 31), en);
      e = exp_q.pop_front(); en = exp_nom_q.pop_front(); es = exp_stall_q.pop_front();
      n_vec += 4;
      if (DECODE_STALL === 1'b1) stall_cycles++;
      if (obs_main() !== e) begin n_fail++; $display("[TB] FAIL div[%0d]: got %h expected %h", n, obs_main(), e); end
      if (DECODE_STALL !== es) begin n_fail++; $display("[TB] FAIL div_stall[%0d]: got %b expected %b", n, DECODE_STALL, es); end
      if (obs_nom() !== en) begin n_fail++; $display("[TB] FAIL div_nom[%0d]: got %h expected %h", n, obs_nom(), en); end
      if (n_DECODE_STALL !== 1'b0) begin n_fail++; $display("[TB] FAIL div_nom_stall[%0d]: got %b expected 0", n, n_DECODE_STALL); end
    end
    n_vec++;
    if (stall_cycles != 31) begin n_fail++; $display("[TB] FAIL div_stall_count: got %0d expected 31", stall_cycles); end
  endtask

  task automatic test_div_flush();
    stim_t s;
    vec_t  e, en;
    logic  es;
    for (int n = 1; n <= 8; n++) begin
      s    = (n == 1) ? i_div() : i_add();
      s.fl = (n == 6);
      e  = (n == 1) ? mk(1, 0, A_DIV, C_R, 1, 0) :
           (n <= 5) ? mk(1, 0, A_DIV, C_R, 0, 0) :
           (n == 6) ? mk(0, 0, A_NOP, 9'b0, 0, 1) : mk(1, 0, A_ADD, C_R, 0, 0);
      en = (n == 1) ? ill() : (n == 6) ? vec_t'(0) : mk(1, 0, A_ADD, C_R, 0, 0);
      drive(s, e, (n <= 5), en);
      e = exp_q.pop_front(); en = exp_nom_q.pop_front(); es = exp_stall_q.pop_front();
      n_vec += 3;
      if (obs_main() !== e) begin n_fail++; $display("[TB] FAIL div_flush[%0d]: got %h expected %h", n, obs_main(), e); end
      if (DECODE_STALL !== es) begin n_fail++; $display("[TB] FAIL div_flush_stall[%0d]: got %b expected %b", n, DECODE_STALL, es); end
      if (obs_nom() !== en) begin n_fail++; $display("[TB] FAIL div_flush_nom[%0d]: got %h expected %h", n, obs_nom(), en); end
    end
  endtask

  task automatic test_reset_busy();
    stim_t s;
    vec_t  e, en;
    logic  es;
    for (int n = 1; n <= 6; n++) begin
      s     = (n == 1) ? i_div() : i_add();
      s.rst = (n == 5);
      e  = (n == 1) ? mk(1, 0, A_DIV, C_R, 1, 0) :
           (n <= 4) ? mk(1, 0, A_DIV, C_R, 0, 0) :
           (n == 5) ? vec_t'(0) : mk(1, 0, A_ADD, C_R, 0, 0);
      en = (n == 1) ? ill() : (n == 5) ? vec_t'(0) : mk(1, 0, A_ADD, C_R, 0, 0);
      drive(s, e, (n <= 4), en);
      e = exp_q.pop_front(); en = exp_nom_q.pop_front(); es = exp_stall_q.pop_front();
      n_vec += 3;
      if (obs_main() !== e) begin n_fail++; $display("[TB] FAIL reset_busy[%0d]: got %h expected %h", n, obs_main(), e); end
      if (DECODE_STALL !== es) begin n_fail++; $display("[TB] FAIL reset_busy_stall[%0d]: got %b expected %b", n, DECODE_STALL, es); end
      if (obs_nom() !== en) begin n_fail++; $display("[TB] FAIL reset_busy_nom[%0d]: got %h expected %h", n, obs_nom(), en); end
    end
  endtask

  task automatic test_mul_stall();
    stim_t s;
    vec_t  e, en;
    logic  es;
    int    stall_cycles = 0;
    int    starts = 0;
    for (int n = 1; n <= 6; n++) begin
      s    = (n == 1) ? ins(7'b0110011, 3'b000, 7'b0000001) : i_add();
      s.st = (n >= 2 && n <= 4);
      e  = (n == 1) ? mk(1, 0, A_MUL, C_R, 1, 0) :
           (n <= 5) ? mk(1, 0, A_MUL, C_R, 0, 0) : mk(1, 0, A_ADD, C_R, 0, 0);
      en = (n <= 4) ? ill() : mk(1, 0, A_ADD, C_R, 0, 0);
      drive(s, e, (n <= 4), en);
      e = exp_q.pop_front(); en = exp_nom_q.pop_front(); es = exp_stall_q.pop_front();
      n_vec += 3;
      if (DECODE_STALL === 1'b1) stall_cycles++;
      if (MULDIV_START === 1'b1) starts++;
      if (obs_main() !== e) begin n_fail++; $display("[TB] FAIL mul_stall[%0d]: got %h expected %h", n, obs_main(), e); end
      if (DECODE_STALL !== es) begin n_fail++; $display("[TB] FAIL mul_stall_stall[%0d]: got %b expected %b", n, DECODE_STALL, es); end
      if (obs_nom() !== en) begin n_fail++; $display("[TB] FAIL mul_stall_nom[%0d]: got %h expected %h", n, obs_nom(), en); end
    end
    n_vec += 2;
    if (stall_cycles != 4) begin n_fail++; $display("[TB] FAIL mul_stall_count: got %0d expected 4", stall_cycles); end
    if (starts != 1) begin n_fail++; $display("[TB] FAIL mul_start_count: got %0d expected 1", starts); end
  endtask

  task automatic test_back_to_back();
    stim_t s;
    vec_t  e, en;
    logic  es;
    for (int n = 1; n <= 5; n++) begin
      s  = (n == 1) ? ins(7'b0110011, 3'b001, 7'b0000001) :
           (n <= 3) ? ins(7'b0110011, 3'b010, 7'b0000001) : i_add();
      e  = (n == 1) ? mk(1, 0, A_MULH, C_R, 1, 0) :
           (n == 2) ? mk(1, 0, A_MULH, C_R, 0, 0) :
           (n == 3) ? mk(1, 0, A_MULHSU, C_R, 1, 0) :
           (n == 4) ? mk(1, 0, A_MULHSU, C_R, 0, 0) : mk(1, 0, A_ADD, C_R, 0, 0);
      en = (n <= 3) ? ill() : mk(1, 0, A_ADD, C_R, 0, 0);
      drive(s, e, (n == 1 || n == 3), en);
      e = exp_q.pop_front(); en = exp_nom_q.pop_front(); es = exp_stall_q.pop_front();
      n_vec += 3;
      if (obs_main() !== e) begin n_fail++; $display("[TB] FAIL back_to_back[%0d]: got %h expected %h", n, obs_main(), e); end
      if (DECODE_STALL !== es) begin n_fail++; $display("[TB] FAIL back_to_back_stall[%0d]: got %b expected %b", n, DECODE_STALL, es); end
      if (obs_nom() !== en) begin n_fail++; $display("[TB] FAIL back_to_back_nom[%0d]: got %h expected %h", n, obs_nom(), en); end
    end
  endtask

  initial begin
    RESET = 1'b1; INSTR_VALID = 1'b0; OPCODE = '0; FUNC3 = '0; FUNC7 = '0;
    STALL_IN = 1'b0; FLUSH = 1'b0;
    $display("[TB] starting control_unit_pipelined bench");
    test_reset();
    test_decode();
    test_stall_flush_idle();
    test_div();
    test_div_flush();
    test_reset_busy();
    test_mul_stall();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/control_unit_pipelined.md
Name: control_unit_pipelined

Overview:
- Next-generation RV32IM decode/control block for the ID stage.
- Decodes OPCODE/FUNC3/FUNC7, including the M extension, into a control bundle and an ALU operation code.
- Registers the bundle into the ID/EX boundary, with stall and flush support.
- Sequences multi-cycle MUL/DIV operations with a busy FSM and back-pressure to fetch/decode.

Parameters:
- ENABLE_M, 1: 1 = decode MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU; 0 = funct7 0000001 is illegal.
- MUL_CYCLES, 2: EX occupancy of MUL-class ops, range 1..15.
- DIV_CYCLES, 32: EX occupancy of DIV/REM-class ops, range 1..63.

Ports:
- CLK  in  1  clock
- RESET  in  1  synchronous active-high reset
- INSTR_VALID  in  1  instruction in ID is valid
- OPCODE  in  7  instr[6:0]
- FUNC3  in  3  instr[14:12]
- FUNC7  in  7  instr[31:25]
- STALL_IN  in  1  hazard-unit stall: hold the ID/EX register
- FLUSH  in  1  branch/jump taken: kill ID/EX contents
- DECODE_STALL  out  1  combinational; high while the FSM is busy, so IF/ID hold
- EX_VALID  out  1  ID/EX holds a real instruction
- WRITE_EN, MEM_WRITE, MEM_READ, BRANCH, JUMP, PC_SELECT, IMM_SELECT, JALR_SELECT, DATA_MEM_SELECT  out  1 each  registered control bits
- ALU_OP  out  5  registered ALU/MULDIV operation (encoding in package)
- MULDIV_START  out  1  one-cycle pulse when a MUL/DIV enters EX
- MULDIV_ABORT  out  1  one-cycle pulse when a busy MUL/DIV is flushed
- ILLEGAL  out  1  registered; the instruction in EX is undecodable

Behaviour:
- Reset: every registered output is 0, FSM = IDLE, counter = 0. DECODE_STALL is 0 in IDLE.
- Precedence each cycle: RESET > FLUSH > STALL_IN > busy countdown > normal load.
- Decode, combinational; any unlisted encoding is illegal:
  - R-type 0110011:
    - FUNC7 0000000 with any FUNC3 is legal.
    - FUNC7 0100000 is legal only with FUNC3 000 or 101.
    - FUNC7 0000001 is legal only when ENABLE_M = 1.
    - Legal R-type sets WRITE_EN.
  - Loads 0000011, FUNC3 in {000,001,010,100,101}: WRITE_EN, MEM_READ, IMM_SELECT, DATA_MEM_SELECT.
  - OP-IMM 0010011: WRITE_EN, IMM_SELECT.
    - FUNC3 001 requires FUNC7 0000000.
    - FUNC3 101 requires FUNC7 0000000 or 0100000.
  - Stores 0100011, FUNC3 in {000,001,010}: MEM_WRITE, IMM_SELECT.
  - Branches 1100011, FUNC3 in {000,001,100,101,110,111}: BRANCH.
  - JAL 1101111: WRITE_EN, JUMP, PC_SELECT.
  - JALR 1100111 with FUNC3 000: WRITE_EN, JUMP, JALR_SELECT, IMM_SELECT.
  - LUI 0110111: WRITE_EN, IMM_SELECT.
  - AUIPC 0010111: WRITE_EN, IMM_SELECT, PC_SELECT.
- Illegal instruction: all control bits 0, ALU_OP = ALU_NOP, ILLEGAL = 1, EX_VALID = 1.
- INSTR_VALID = 0: a bubble is loaded (all outputs 0).
- Latency: decode is loaded into ID/EX at the next rising CLK (1 cycle).
- FSM states IDLE, MUL_BUSY, DIV_BUSY:
  - IDLE:
    - A valid M-op with FUNC3 0-3 (MUL class) and MUL_CYCLES > 1 loads, pulses MULDIV_START, loads the counter with MUL_CYCLES-1, and moves to MUL_BUSY.
    - FUNC3 4-7 (DIV class) does the same with DIV_CYCLES and DIV_BUSY.
    - An N_CYCLES = 1 op pulses MULDIV_START and stays in IDLE.
  - BUSY:
    - The ID/EX register holds its contents; MULDIV_START = 0; DECODE_STALL = 1; the counter decrements each cycle STALL_IN = 0.
    - When the counter is 1 and decrementing, return to IDLE; the next instruction is loaded on the following edge.
- STALL_IN: freezes the ID/EX register and the counter in any state. MULDIV_START does not re-pulse.
- FLUSH:
  - In IDLE: loads a bubble.
  - In BUSY: loads a bubble, moves to IDLE, clears the counter, pulses MULDIV_ABORT.
  - FLUSH with STALL_IN: FLUSH wins.
- RESET mid-BUSY: immediate return to IDLE with no ABORT pulse.

Decomposition:
- Package rv32_ctrl_pkg holds:
  - opcode constants (OP_R, OP_LOAD, OP_IMM, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC);
  - the FUNC7 constants F7_BASE, F7_ALT, F7_MULDIV;
  - the 5-bit ALU_OP encodings (ALU_NOP = 0, ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, LUI, MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU);
  - the FSM state encoding.
- One sub-module, ctrl_decode: pure combinational decode producing the bundle, ALU_OP, ILLEGAL, IS_MUL and IS_DIV. The top holds the ID/EX register, FSM and counter.

Test Plan:
- Reset, then ADD (0110011/000/0000000) with INSTR_VALID = 1 → after one edge: EX_VALID = 1, WRITE_EN = 1, ALU_OP = ADD, ILLEGAL = 0; DECODE_STALL = 0 throughout.
- SW (0100011/010) then LW (0000011/010) → MEM_WRITE = 1 and IMM_SELECT = 1, then MEM_READ = 1, WRITE_EN = 1, DATA_MEM_SELECT = 1, on consecutive cycles.
- DIV (0110011/100/0000001), DIV_CYCLES = 32 → MULDIV_START pulses for 1 cycle; DECODE_STALL = 1 for exactly 31 cycles; EX holds DIV; the next instruction appears on cycle 33.
- DIV issued, FLUSH asserted on busy cycle 5 → bubble next cycle, MULDIV_ABORT = 1 for 1 cycle, FSM in IDLE, DECODE_STALL = 0.
- MUL with MUL_CYCLES = 2 and STALL_IN held for 3 cycles mid-op → the counter freezes; DECODE_STALL stays high 1 + 3 = 4 cycles; no second START.
- ENABLE_M = 0 with MUL, and SUB-encoded shift 0110011/001/0100000 → ILLEGAL = 1, all control bits 0, ALU_OP = ALU_NOP, no FSM transition.
